// File: rtl/player_hit_ctrl.sv
// Per-frame moon/player collision test (3-stage squared-distance pipeline)
// feeding a lives / invulnerability / game-over state machine.
module player_hit_ctrl #(
  parameter int HIT_RADIUS    = 40,
  parameter int PLAYER_RADIUS = 4,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       moon_active,
  input  logic [9:0] moon_x,
  input  logic [9:0] moon_y,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       restart,
  output logic [2:0] lives,
  output logic       hit_pulse,
  output logic       invuln,
  output logic       player_visible,
  output logic       game_over
);

  // state   | meaning
  // ALIVE   | vulnerable, hits cost a life
  // INVULN  | post-hit grace period, player blinks
  // DEAD    | no lives left, waiting for restart
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  localparam int          REACH   = HIT_RADIUS + PLAYER_RADIUS;
  localparam logic [20:0] REACH_SQ = 21'(REACH * REACH);

  state_t      state, state_n;
  logic [2:0]  lives_n;
  logic [7:0]  inv_cnt, inv_cnt_n;
  logic [3:0]  blink_cnt, blink_cnt_n;
  logic        pulse_n;

  logic [10:0] dx, dy, dx_abs, dy_abs;
  logic [9:0]  adx, ady;
  logic [19:0] dx2, dy2;
  logic [20:0] d2;
  logic        v1, v2, hit_raw;
  logic        flush;

  // 11-bit differences keep the sign, so no wrap for large offsets
  assign dx     = {1'b0, player_x} - {1'b0, moon_x};
  assign dy     = {1'b0, player_y} - {1'b0, moon_y};
  assign dx_abs = dx[10] ? (~dx + 11'd1) : dx;
  assign dy_abs = dy[10] ? (~dy + 11'd1) : dy;
  assign d2     = 21'(dx2) + 21'(dy2);
  assign flush  = restart && (state == DEAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adx     <= '0;
      ady     <= '0;
      v1      <= 1'b0;
      dx2     <= '0;
      dy2     <= '0;
      v2      <= 1'b0;
      hit_raw <= 1'b0;
    end else begin
      if (frame_tick) begin
        adx <= dx_abs[9:0];
        ady <= dy_abs[9:0];
      end
      v1      <= frame_tick && moon_active && !flush;
      dx2     <= 20'(adx) * 20'(adx);
      dy2     <= 20'(ady) * 20'(ady);
      v2      <= v1 && !flush;
      hit_raw <= v2 && !flush && (d2 <= REACH_SQ);
    end
  end

  always_comb begin
    state_n     = state;
    lives_n     = lives;
    inv_cnt_n   = inv_cnt;
    blink_cnt_n = blink_cnt;
    pulse_n     = 1'b0;
    case (state)
      ALIVE: begin
        if (hit_raw) begin
          pulse_n = 1'b1;
          lives_n = lives - 3'd1;
          if (lives == 3'd1) begin
            state_n = DEAD;
          end else begin
            state_n     = INVULN;
            inv_cnt_n   = 8'(INVULN_FRAMES);
            blink_cnt_n = 4'd0;
          end
        end
      end
      INVULN: begin
        if (frame_tick) begin
          blink_cnt_n = blink_cnt + 4'd1;
          inv_cnt_n   = inv_cnt - 8'd1;
          if (inv_cnt == 8'd1) state_n = ALIVE;
        end
      end
      DEAD: begin
        if (restart) begin
          lives_n = 3'(LIVES_INIT);
          state_n = ALIVE;
        end
      end
      default: state_n = ALIVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ALIVE;
      lives          <= 3'(LIVES_INIT);
      inv_cnt        <= '0;
      blink_cnt      <= '0;
      hit_pulse      <= 1'b0;
      invuln         <= 1'b0;
      player_visible <= 1'b1;
      game_over      <= 1'b0;
    end else begin
      state          <= state_n;
      lives          <= lives_n;
      inv_cnt        <= inv_cnt_n;
      blink_cnt      <= blink_cnt_n;
      hit_pulse      <= pulse_n;
      invuln         <= (state_n == INVULN);
      game_over      <= (state_n == DEAD);
      player_visible <= (state_n == ALIVE) || ((state_n == INVULN) && blink_cnt_n[3]);
    end
  end

endmodule
